// File: rtl/trx_stream_core_if.sv
// Host-side sample stream: {I,Q} beats tagged with channel index, valid/ready handshake.
interface trx_stream_core_if #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int CHAN_BITS    = 1
) ();
  logic [2*SAMPLE_WIDTH-1:0] m_data;
  logic [CHAN_BITS-1:0]      m_chan;
  logic                      m_last;
  logic                      m_valid;
  logic                      m_ready;

  modport master (output m_data, m_chan, m_last, m_valid, input m_ready);
  modport slave  (input m_data, m_chan, m_last, m_valid, output m_ready);
endinterface

// File: rtl/trx_stream_core.sv
// Transceiver glue: RX/TX sequencing with T/R turnaround, plus NCHAN-wide I/Q frame
// capture serialised into a first-word-fall-through FIFO feeding the host stream.
module trx_stream_core #(
  parameter int NCHAN        = 2,
  parameter int CHAN_BITS    = 1,
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 16,
  parameter int TURNAROUND   = 64
) (
  input  logic                          clock,
  input  logic                          not_reset,
  input  logic                          run,
  input  logic                          ptt,
  input  logic                          loopback,
  input  logic                          rx_strobe,
  input  logic [NCHAN*SAMPLE_WIDTH-1:0] ch_data_I,
  input  logic [NCHAN*SAMPLE_WIDTH-1:0] ch_data_Q,
  output logic                          rx_enable,
  output logic                          tx_enable,
  output logic [2:0]                    mode_state,
  trx_stream_core_if.master             m,
  output logic [15:0]                   overflow_count
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ALLOC_W = AW + 1;
  localparam int EW      = CHAN_BITS + 2*SAMPLE_WIDTH;
  localparam int CNT_W   = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [CNT_W-1:0]     TURN_LOAD = CNT_W'(TURNAROUND - 1);
  localparam logic [ALLOC_W-1:0]   ALLOC_MAX = ALLOC_W'(FIFO_DEPTH - NCHAN);
  localparam logic [CHAN_BITS-1:0] LAST_CH   = CHAN_BITS'(NCHAN - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX       = 3'd1,
    RX_TO_TX = 3'd2,
    TX       = 3'd3,
    TX_TO_RX = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!run) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nx = RX;
        RX: if (ptt) begin
          state_nx = RX_TO_TX;
          cnt_nx   = TURN_LOAD;
        end
        RX_TO_TX: begin
          if (!ptt) begin
            state_nx = TX_TO_RX;
            cnt_nx   = TURN_LOAD;
          end else if (cnt == '0) state_nx = TX;
          else                    cnt_nx   = cnt - 1'b1;
        end
        TX: if (!ptt) begin
          state_nx = TX_TO_RX;
          cnt_nx   = TURN_LOAD;
        end
        TX_TO_RX: begin
          if (ptt) begin
            state_nx = RX_TO_TX;
            cnt_nx   = TURN_LOAD;
          end else if (cnt == '0) state_nx = RX;
          else                    cnt_nx   = cnt - 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Enables are registered from the next state so they change on the same edge as mode_state.
  always_ff @(posedge clock) begin
    if (!not_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rx_enable <= 1'b0;
      tx_enable <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rx_enable <= (state_nx == RX) || ((state_nx == TX) && loopback);
      tx_enable <= (state_nx == TX);
    end
  end

  assign mode_state = state;

  // alloc counts stored plus reserved-but-unwritten entries, so a frame is never split.
  logic [ALLOC_W-1:0]      alloc;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    busy;
  logic [CHAN_BITS-1:0]    idx;
  logic [SAMPLE_WIDTH-1:0] lat_i [NCHAN];
  logic [SAMPLE_WIDTH-1:0] lat_q [NCHAN];
  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [EW-1:0]           head;
  logic                    accepting, room, accept, drop, rd_fire;

  assign accepting = (state == RX) || ((state == TX) && loopback);
  assign room      = (alloc <= ALLOC_MAX) && !busy;
  assign accept    = rx_strobe && accepting && room;
  assign drop      = rx_strobe && accepting && !room;
  assign rd_fire   = m.m_valid && m.m_ready;

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int unsigned k = 0; k < NCHAN; k++) begin
        lat_i[k] <= ch_data_I[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        lat_q[k] <= ch_data_Q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
    if (busy) mem[wr_ptr[AW-1:0]] <= {idx, lat_i[idx], lat_q[idx]};
  end

  always_ff @(posedge clock) begin
    if (!not_reset) begin
      alloc          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      busy           <= 1'b0;
      idx            <= '0;
      overflow_count <= '0;
    end else begin
      alloc <= alloc + (accept ? ALLOC_W'(NCHAN) : '0) - (rd_fire ? ALLOC_W'(1) : '0);
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      if (accept) begin
        busy <= 1'b1;
        idx  <= '0;
      end else if (busy) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (idx == LAST_CH) busy <= 1'b0;
        else                idx  <= idx + 1'b1;
      end
      if (drop && (overflow_count != 16'hFFFF)) overflow_count <= overflow_count + 16'd1;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign m.m_valid = (wr_ptr != rd_ptr);
  assign m.m_data  = m.m_valid ? head[2*SAMPLE_WIDTH-1:0] : '0;
  assign m.m_chan  = m.m_valid ? head[EW-1 -: CHAN_BITS] : '0;
  assign m.m_last  = m.m_valid && (head[EW-1 -: CHAN_BITS] == LAST_CH);
endmodule

// File: tb/tb_trx_stream_core.sv
// Directed bench for trx_stream_core: transaction-level model compared every cycle,
// plus literal expectations for reset, beat contents, overflow and turnaround timing.
module tb_trx_stream_core;
  localparam int NCHAN = 2, CHAN_BITS = 1, SW = 24, DEPTH = 16, TURN = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  not_reset, run, ptt, loopback, rx_strobe;
  logic [NCHAN*SW-1:0]   ch_i, ch_q;
  logic                  rx_enable, tx_enable;
  logic [2:0]            mode_state;
  logic [15:0]           overflow_count;

  trx_stream_core_if #(.SAMPLE_WIDTH(SW), .CHAN_BITS(CHAN_BITS)) s_if ();

  trx_stream_core #(
    .NCHAN(NCHAN), .CHAN_BITS(CHAN_BITS), .SAMPLE_WIDTH(SW),
    .FIFO_DEPTH(DEPTH), .TURNAROUND(TURN)
  ) dut (
    .clock(clock), .not_reset(not_reset), .run(run), .ptt(ptt), .loopback(loopback),
    .rx_strobe(rx_strobe), .ch_data_I(ch_i), .ch_data_Q(ch_q),
    .rx_enable(rx_enable), .tx_enable(tx_enable), .mode_state(mode_state),
    .m(s_if), .overflow_count(overflow_count)
  );

  int n_checks = 0, n_fail = 0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { int chan; logic [2*SW-1:0] data; bit last; } beat_t;

  // Transaction-level model: dead time measured as elapsed cycles since the switch began.
  int      ms = 0;
  longint  cyc = 0, t0 = 0;
  bit      exp_rx = 0, exp_tx = 0;
  int      exp_ovf = 0;
  beat_t   mfifo[$], mpend[$], log_q[$];
  bit      m_acc, m_busy, m_room, m_read;
  beat_t   mb;

  initial forever begin
    @(posedge clock);
    cyc++;
    if (!not_reset) begin
      ms = 0; exp_rx = 0; exp_tx = 0; exp_ovf = 0;
      mfifo.delete(); mpend.delete();
    end else begin
      m_acc  = (ms == 1) || (ms == 3 && loopback);
      m_busy = mpend.size() != 0;
      m_room = (DEPTH - mfifo.size() - mpend.size()) >= NCHAN;
      m_read = mfifo.size() != 0 && s_if.m_ready;
      if (m_read) void'(mfifo.pop_front());
      if (m_busy) mfifo.push_back(mpend.pop_front());
      if (rx_strobe && m_acc) begin
        if (!m_busy && m_room) begin
          for (int k = 0; k < NCHAN; k++) begin
            mb.chan = k;
            mb.data = {ch_i[k*SW +: SW], ch_q[k*SW +: SW]};
            mb.last = (k == NCHAN-1);
            mpend.push_back(mb);
          end
        end else if (exp_ovf < 65535) exp_ovf++;
      end
      if (!run) ms = 0;
      else case (ms)
        0: ms = 1;
        1: if (ptt) begin ms = 2; t0 = cyc; end
        2: if (!ptt) begin ms = 4; t0 = cyc; end else if (cyc - t0 == TURN) ms = 3;
        3: if (!ptt) begin ms = 4; t0 = cyc; end
        4: if (ptt) begin ms = 2; t0 = cyc; end else if (cyc - t0 == TURN) ms = 1;
        default: ms = 0;
      endcase
      exp_rx = (ms == 1) || (ms == 3 && loopback);
      exp_tx = (ms == 3);
    end
  end

  bit cmp_on = 0;
  initial forever begin
    @(negedge clock);
    if (cmp_on) begin
      check("mode_state", mode_state, ms);
      check("rx_enable", rx_enable, exp_rx);
      check("tx_enable", tx_enable, exp_tx);
      check("overflow_count", overflow_count, exp_ovf);
      check("m_valid", s_if.m_valid, mfifo.size() != 0);
      if (mfifo.size() != 0) begin
        check("m_data", s_if.m_data, mfifo[0].data);
        check("m_chan", s_if.m_chan, mfifo[0].chan);
        check("m_last", s_if.m_last, mfifo[0].last);
      end
    end
    if (s_if.m_valid && s_if.m_ready) begin
      mb.chan = int'(s_if.m_chan);
      mb.data = s_if.m_data;
      mb.last = s_if.m_last;
      log_q.push_back(mb);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic strobe(logic [NCHAN*SW-1:0] i, logic [NCHAN*SW-1:0] q);
    ch_i = i; ch_q = q; rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  int  dead;
  bit  tx_seen;

  initial begin
    not_reset = 0; run = 0; ptt = 0; loopback = 0; rx_strobe = 0;
    ch_i = '0; ch_q = '0; s_if.m_ready = 1;
    tick(3);
    cmp_on = 1;
    check("reset mode_state", mode_state, 0);
    check("reset rx_enable", rx_enable, 0);
    check("reset tx_enable", tx_enable, 0);
    check("reset m_valid", s_if.m_valid, 0);
    check("reset m_data", s_if.m_data, 0);
    check("reset m_chan", s_if.m_chan, 0);
    check("reset m_last", s_if.m_last, 0);
    check("reset overflow", overflow_count, 0);

    not_reset = 1; run = 1;
    tick();
    check("run mode_state", mode_state, 1);
    check("run rx_enable", rx_enable, 1);
    check("run tx_enable", tx_enable, 0);

    // Single frame, streamed straight out
    log_q.delete();
    strobe({24'h000003, 24'h000001}, {24'h000004, 24'h000002});
    tick(6);
    check("frame beats", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("beat0 chan", log_q[0].chan, 0);
      check("beat0 data", log_q[0].data, 48'h000001000002);
      check("beat0 last", log_q[0].last, 0);
      check("beat1 chan", log_q[1].chan, 1);
      check("beat1 data", log_q[1].data, 48'h000003000004);
      check("beat1 last", log_q[1].last, 1);
    end

    // Fill the FIFO with m_ready low: 8 frames fit, 2 dropped
    s_if.m_ready = 0;
    log_q.delete();
    for (int f = 0; f < 10; f++) begin
      strobe({24'(f*16+3), 24'(f*16+1)}, {24'(f*16+4), 24'(f*16+2)});
      tick(3);
    end
    tick(4);
    check("overflow after fill", overflow_count, 2);
    check("no beats while stalled", log_q.size(), 0);
    check("valid while stalled", s_if.m_valid, 1);
    s_if.m_ready = 1;
    tick(20);
    check("drain beats", log_q.size(), 16);
    if (log_q.size() >= 16) begin
      check("drain first data", log_q[0].data, 48'h000001000002);
      check("drain last data", log_q[15].data, 48'h000073000074);
      for (int b = 0; b < 16; b++) begin
        check("drain chan", log_q[b].chan, b % 2);
        check("drain last flag", log_q[b].last, b % 2);
      end
    end

    // RX -> TX turnaround
    ptt = 1; dead = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (tx_enable) break;
      if (!rx_enable && !tx_enable) dead++;
    end
    check("rx->tx dead cycles", dead, 64);
    check("tx mode_state", mode_state, 3);
    ptt = 0; dead = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (rx_enable) break;
      if (!rx_enable && !tx_enable) dead++;
    end
    check("tx->rx dead cycles", dead, 64);
    check("back to rx mode_state", mode_state, 1);

    // Abort RX_TO_TX after 30 cycles
    ptt = 1; dead = 0; tx_seen = 0;
    repeat (30) begin
      tick();
      if (tx_enable) tx_seen = 1;
      if (!rx_enable && !tx_enable) dead++;
    end
    ptt = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (tx_enable) tx_seen = 1;
      if (rx_enable) break;
      if (!rx_enable && !tx_enable) dead++;
    end
    check("abort dead cycles", dead, 94);
    check("abort tx never on", tx_seen, 0);
    check("abort mode_state", mode_state, 1);

    // TX: ignored without loopback, accepted with it
    ptt = 1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (tx_enable) break;
    end
    check("tx reached", mode_state, 3);
    log_q.delete();
    strobe({24'h111111, 24'h222222}, {24'h333333, 24'h444444});
    tick(5);
    check("tx no-loop overflow", overflow_count, 2);
    check("tx no-loop beats", log_q.size(), 0);
    loopback = 1;
    tick();
    check("loopback rx_enable", rx_enable, 1);
    strobe({24'hAAAAAA, 24'h555555}, {24'h123456, 24'h654321});
    tick(5);
    check("loopback beats", log_q.size(), 2);
    if (log_q.size() >= 1) check("loopback data", log_q[0].data, 48'h555555654321);
    check("loopback overflow", overflow_count, 2);

    // Reset in the middle of serialisation
    s_if.m_ready = 0;
    strobe({24'hBEEF01, 24'hBEEF00}, {24'hCAFE01, 24'hCAFE00});
    tick();
    check("mid-frame valid", s_if.m_valid, 1);
    not_reset = 0;
    tick();
    check("mid reset m_valid", s_if.m_valid, 0);
    check("mid reset mode", mode_state, 0);
    check("mid reset tx_enable", tx_enable, 0);
    not_reset = 1; ptt = 0; loopback = 0; s_if.m_ready = 1;
    log_q.delete();
    tick(10);
    check("no stale beats", log_q.size(), 0);
    check("post reset mode", mode_state, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trx_stream_core.md
Name: trx_stream_core

Overview:
- Parametrised successor to the transceiver top-level glue.
- Sequences the AD9866 between receive and transmit with a programmable T/R turnaround, and supports loopback.
- Packs NCHAN simultaneous receiver I/Q outputs into a buffered, handshaked sample stream for the host side.
- Sits between the per-channel receiver instances, the ad9866 modem block and the stream interface to the ARM.

Parameters:
NCHAN, 2, number of receive channels sampled together (1..8)
CHAN_BITS, 1, width of channel index; 2**CHAN_BITS >= NCHAN
SAMPLE_WIDTH, 24, bits per I or Q sample
FIFO_DEPTH, 16, FIFO entries, power of two, >= NCHAN
TURNAROUND, 64, clock cycles of dead time on every RX<->TX switch (>= 1)

Ports:
clock  in  1  system clock (hw_rx_clock/2 domain)
not_reset  in  1  synchronous active-low reset
run  in  1  1 = transceiver active; 0 = force IDLE
ptt  in  1  transmit request, level-sensitive
loopback  in  1  accept RX frames while in TX
rx_strobe  in  1  one-cycle pulse: all channel samples valid this cycle
ch_data_I  in  NCHAN*SAMPLE_WIDTH  channel k at bits [k*SW +: SW]
ch_data_Q  in  NCHAN*SAMPLE_WIDTH  same packing
rx_enable  out  1  to ad9866 rx_enable
tx_enable  out  1  to ad9866 tx_enable
mode_state  out  3  current FSM state
m_data  out  2*SAMPLE_WIDTH  {I,Q}, I in upper half
m_chan  out  CHAN_BITS  channel index of m_data
m_last  out  1  1 when m_chan == NCHAN-1
m_valid  out  1  stream valid
m_ready  in  1  stream ready
overflow_count  out  16  dropped frames, saturating

Behaviour:
- Reset (not_reset=0 at an edge): state IDLE, rx_enable=0, tx_enable=0, counter=0, FIFO emptied, serialiser idle, m_valid=0, m_data=0, m_chan=0, m_last=0, overflow_count=0. An in-flight frame is discarded.
- State encoding: IDLE=0, RX=1, RX_TO_TX=2, TX=3, TX_TO_RX=4. All outputs are registered.
- FSM transitions, evaluated per edge with highest priority first:
  - run=0 in any state -> IDLE.
  - IDLE & run -> RX.
  - RX & ptt -> RX_TO_TX, counter loaded with TURNAROUND-1.
  - RX_TO_TX: counter decrements; at 0 -> TX. If ptt=0 before expiry -> TX_TO_RX with counter reloaded.
  - TX & !ptt -> TX_TO_RX, counter reloaded.
  - TX_TO_RX: counter decrements; at 0 -> RX. If ptt=1 before expiry -> RX_TO_TX with counter reloaded.
- Enable outputs by state:
  - rx_enable=1 in RX, and in TX when loopback=1.
  - tx_enable=1 only in TX.
  - Both enables are 0 in IDLE and in the turnaround states.
  - Entering TX takes exactly TURNAROUND cycles after entering RX_TO_TX.
- Frame accept: a frame is accepted when rx_strobe=1, state is RX (or TX with loopback=1), the serialiser is idle, and free FIFO slots >= NCHAN.
  - On accept, all NCHAN I/Q pairs are latched.
  - Slots are reserved at accept time, so later reads can only increase free space.
- Frame drop:
  - If rx_strobe=1 in an accepting state but the serialiser is busy or free slots < NCHAN, the whole frame is dropped and overflow_count increments (holds at 16'hFFFF).
  - Strobes in non-accepting states are ignored and not counted.
  - A frame is never partially written.
- Serialiser: channel k is written to the FIFO at edge e+1+k, where e is the accept edge. Each entry is {k, I_k, Q_k}. The serialiser is busy for NCHAN cycles.
- FIFO read side: first-word-fall-through.
  - m_valid=1 whenever the FIFO is non-empty; first data appears the cycle after the channel-0 write edge.
  - A transfer occurs on m_valid & m_ready.
  - m_data, m_chan and m_last hold stable while m_valid & !m_ready.
  - Simultaneous read and write on a full or empty FIFO behave correctly; occupancy stays consistent.
- A state change mid-frame (e.g. run=0) does not abort the serialiser; the frame completes. The FIFO is not flushed by run=0.
- Pointer wrap-around is modulo FIFO_DEPTH, with a full/empty distinction via an extra pointer bit.

Test Plan:
- Reset, then run=1 -> mode_state 0->1 on the next edge, rx_enable=1, tx_enable=0, m_valid=0, overflow_count=0.
- In RX, TURNAROUND=64: raise ptt -> both enables 0 for exactly 64 cycles, then tx_enable=1, mode_state=3. Drop ptt -> 64 dead cycles, then rx_enable=1.
- NCHAN=2, m_ready=1, strobe with I0=0x000001, Q0=0x000002, I1=0x000003, Q1=0x000004 -> two beats: {chan 0, 0x000001000002, last 0}, {chan 1, 0x000003000004, last 1}.
- m_ready=0, FIFO_DEPTH=16, 10 strobes spaced 4 cycles apart -> 8 frames stored, overflow_count=2. Then m_ready=1 -> 16 beats in channel order, with m_last on every second beat.
- ptt toggled off at cycle 30 of RX_TO_TX -> goes to TX_TO_RX, returns to RX 64 cycles later, tx_enable never 1. Strobes in TX with loopback=0 are ignored (count unchanged); with loopback=1 they are accepted and rx_enable=1.
- not_reset=0 mid-serialisation with m_valid=1 -> next edge: m_valid=0, FIFO empty, state IDLE, no stale beats after reset is released.
